// File: rtl/spi_master.sv
// SPI master: shifts one WIDTH-bit word out on SDI (MSB first) while sampling SDO.
// SCK is derived from the system clock by a half-period tick counter.
// After the word, CSX is held for one extra half period before DONE.
module spi_master #(
  parameter int CLK_FREQ = 100000000,
  parameter int SPI_FREQ = 1000000,
  parameter int WIDTH    = 8,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0
) (
  input  logic             CLK_100MHz,
  input  logic             RST,
  input  logic             LOAD,
  input  logic             HOLD,
  input  logic [WIDTH-1:0] IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic             SCK,
  output logic             SDI,
  input  logic             SDO,
  output logic             CSX
);

  // Half SCK period in system clocks, never below one.
  localparam int HALF_RAW = CLK_FREQ / SPI_FREQ / 2;
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  // The half-period counter only ever holds 0..HALF-1.
  localparam int HW       = (HALF < 2) ? 1 : $clog2(HALF);
  localparam int NTOG     = 2 * WIDTH;
  localparam int TW       = $clog2(NTOG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [HW-1:0]    hcnt;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] tx;
  logic [WIDTH-1:0] tx_shl;
  logic [WIDTH-1:0] rx;
  logic             hold_flag;
  logic             tick;
  logic             last_tog;
  logic             sample_tog;

  // Tick and toggle decode; sample_tog marks the toggles on which SDO is captured.
  always_comb begin
    tick       = (hcnt == HW'(HALF - 1));
    last_tog   = (tcnt == TW'(NTOG - 1));
    sample_tog = (~tcnt[0]) ^ CPHA;
    tx_shl     = tx << 1;
  end

  // State register.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; any unused encoding falls back to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (LOAD) state_nx = S_XFER;
      S_XFER:  if (tick && last_tog) state_nx = S_TAIL;
      S_TAIL:  if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters, shift registers and registered outputs.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      hcnt      <= '0;
      tcnt      <= '0;
      tx        <= '0;
      rx        <= '0;
      hold_flag <= 1'b0;
      SCK       <= CPOL;
      SDI       <= 1'b0;
      CSX       <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OUT       <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          hcnt <= '0;
          tcnt <= '0;
          if (LOAD) begin
            tx        <= IN;
            rx        <= '0;
            hold_flag <= HOLD;
            CSX       <= 1'b0;
            BUSY      <= 1'b1;
            // Leading-edge sampling needs the first bit on the wire before SCK moves.
            if (!CPHA) SDI <= IN[WIDTH-1];
          end
        end
        S_XFER: begin
          if (tick) begin
            hcnt <= '0;
            SCK  <= ~SCK;
            tcnt <= last_tog ? '0 : tcnt + 1'b1;
            if (sample_tog) begin
              rx <= (rx << 1) | WIDTH'(SDO);
            end else if (CPHA) begin
              SDI <= tx[WIDTH-1];
              tx  <= tx_shl;
            end else if (!last_tog) begin
              SDI <= tx_shl[WIDTH-1];
              tx  <= tx_shl;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_TAIL: begin
          if (tick) begin
            hcnt <= '0;
            DONE <= 1'b1;
            OUT  <= rx;
            BUSY <= 1'b0;
            SDI  <= 1'b0;
            if (!hold_flag) CSX <= 1'b1;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          hcnt <= '0;
          tcnt <= '0;
          BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master: three instances cover default mode,
// CPOL=1/CPHA=1, and a 16-bit word at the fastest SCK rate.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance 0: defaults, SDO looped back to SDI.
  logic       load0, hold0, busy0, done0, sck0, sdi0, sdo0, csx0;
  logic [7:0] in0, out0;
  assign sdo0 = sdi0;

  // Instance 1: CPOL=1, CPHA=1, SDO stuck high.
  logic       load1, hold1, busy1, done1, sck1, sdi1, sdo1, csx1;
  logic [7:0] in1, out1;
  assign sdo1 = 1'b1;

  // Instance 2: 16-bit word, HALF=1, looped back.
  logic        load2, hold2, busy2, done2, sck2, sdi2, sdo2, csx2;
  logic [15:0] in2, out2;
  assign sdo2 = sdi2;

  spi_master dut0 (
    .CLK_100MHz(clk), .RST(rst), .LOAD(load0), .HOLD(hold0), .IN(in0),
    .BUSY(busy0), .DONE(done0), .OUT(out0), .SCK(sck0), .SDI(sdi0),
    .SDO(sdo0), .CSX(csx0)
  );

  spi_master #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .CLK_100MHz(clk), .RST(rst), .LOAD(load1), .HOLD(hold1), .IN(in1),
    .BUSY(busy1), .DONE(done1), .OUT(out1), .SCK(sck1), .SDI(sdi1),
    .SDO(sdo1), .CSX(csx1)
  );

  spi_master #(.WIDTH(16), .SPI_FREQ(50000000)) dut2 (
    .CLK_100MHz(clk), .RST(rst), .LOAD(load2), .HOLD(hold2), .IN(in2),
    .BUSY(busy2), .DONE(done2), .OUT(out2), .SCK(sck2), .SDI(sdi2),
    .SDO(sdo2), .CSX(csx2)
  );

  int checks = 0;
  int failures = 0;

  // Free-running event counters, read as deltas by the main sequence.
  int         rise0 = 0, done_cnt0 = 0, csx_hi0 = 0, sdi_hi0 = 0;
  logic [7:0] cap0 = 8'h00;
  logic       sck0_q = 1'b0;
  int         viol1 = 0;
  logic [7:0] cap1 = 8'h00;
  logic       sck1_q = 1'b1;
  logic       sdi1_q = 1'b0;

  // Observe instance 0: SCK rising edges, SDI at those edges, DONE/CSX/SDI levels.
  always @(negedge clk) begin
    if (sck0 === 1'b1 && sck0_q === 1'b0) begin
      rise0++;
      cap0 = {cap0[6:0], sdi0};
    end
    sck0_q = sck0;
    if (done0 === 1'b1) done_cnt0++;
    if (csx0 === 1'b1) csx_hi0++;
    if (sdi0 === 1'b1) sdi_hi0++;
  end

  // Observe instance 1: SDI may only change together with a falling SCK edge.
  always @(negedge clk) begin
    if (sck1 === 1'b1 && sck1_q === 1'b0) cap1 = {cap1[6:0], sdi1};
    if (sdi1 !== sdi1_q && done1 !== 1'b1 && !(sck1_q === 1'b1 && sck1 === 1'b0))
      viol1++;
    sck1_q = sck1;
    sdi1_q = sdi1;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Counts cycles from the accept edge until DONE is seen; bounded.
  task automatic wait_done(input int which, output int k);
    k = 0;
    while (sel_done(which) !== 1'b1 && k < 3000) begin
      step();
      k++;
    end
  endtask

  int k, d, r, c, s, v;

  // Directed sequence.
  initial begin
    rst = 1'b1;
    load0 = 1'b0; hold0 = 1'b0; in0 = 8'h00;
    load1 = 1'b0; hold1 = 1'b0; in1 = 8'h00;
    load2 = 1'b0; hold2 = 1'b0; in2 = 16'h0000;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_sck0", sck0, 1'b0);
    check("rst_sdi0", sdi0, 1'b0);
    check("rst_csx0", csx0, 1'b1);
    check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_out0", out0, 8'h00);
    check("rst_sck1", sck1, 1'b1);
    check("rst_csx1", csx1, 1'b1);
    check("rst_out2", out2, 16'h0000);

    // Basic 0xA5 loopback word
    r = rise0; d = done_cnt0;
    in0 = 8'hA5; hold0 = 1'b0; load0 = 1'b1;
    step();
    load0 = 1'b0;
    check("a5_busy_at_accept", busy0, 1'b1);
    check("a5_csx_at_accept", csx0, 1'b0);
    check("a5_first_sdi", sdi0, 1'b1);
    wait_done(0, k);
    check("a5_latency", k, 850);
    check("a5_out", out0, 8'hA5);
    check("a5_csx_after", csx0, 1'b1);
    check("a5_busy_in_done", busy0, 1'b0);
    check("a5_sck_rises", rise0 - r, 8);
    check("a5_sdi_bits", cap0, 8'hA5);
    step();
    check("a5_done_pulse_width", done0, 1'b0);
    check("a5_done_count", done_cnt0 - d, 1);

    // Reset mid-transfer at cycle 300
    d = done_cnt0;
    in0 = 8'h5A; load0 = 1'b1;
    step();
    load0 = 1'b0;
    repeat (299) step();
    check("abort_sck_before", sck0, 1'b1);
    check("abort_busy_before", busy0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_csx", csx0, 1'b1);
    check("abort_sck", sck0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_done", done0, 1'b0);
    check("abort_out", out0, 8'h00);
    check("abort_sdi", sdi0, 1'b0);
    repeat (1000) step();
    check("abort_no_done", done_cnt0 - d, 0);

    // Reset wins over LOAD on the same edge
    rst = 1'b1; load0 = 1'b1; in0 = 8'hFF;
    step();
    rst = 1'b0; load0 = 1'b0;
    check("rst_over_load_busy", busy0, 1'b0);
    check("rst_over_load_csx", csx0, 1'b1);

    // HOLD=1 word followed back-to-back by a HOLD=0 word
    d = done_cnt0; c = csx_hi0; r = rise0;
    in0 = 8'h12; hold0 = 1'b1; load0 = 1'b1;
    step();
    load0 = 1'b0; hold0 = 1'b0;
    wait_done(0, k);
    check("hold_first_latency", k, 850);
    check("hold_first_out", out0, 8'h12);
    check("hold_csx_in_done", csx0, 1'b0);
    check("hold_busy_in_done", busy0, 1'b0);
    in0 = 8'h34; hold0 = 1'b0; load0 = 1'b1;
    step();
    load0 = 1'b0;
    check("b2b_accept_busy", busy0, 1'b1);
    check("b2b_accept_csx", csx0, 1'b0);
    wait_done(0, k);
    check("b2b_second_latency", k, 850);
    check("b2b_second_out", out0, 8'h34);
    check("b2b_csx_after", csx0, 1'b1);
    check("b2b_csx_high_samples", csx_hi0 - c, 1);
    check("b2b_sck_rises", rise0 - r, 16);
    step();
    check("b2b_done_count", done_cnt0 - d, 2);

    // LOAD pulsed mid-transfer is ignored
    d = done_cnt0; s = sdi_hi0;
    in0 = 8'h00; hold0 = 1'b0; load0 = 1'b1;
    step();
    load0 = 1'b0;
    k = 0;
    while (done0 !== 1'b1 && k < 3000) begin
      if (k == 200) begin
        in0 = 8'hFF; load0 = 1'b1;
      end else if (k == 201) begin
        in0 = 8'h00; load0 = 1'b0;
      end
      step();
      k++;
    end
    check("ignore_latency", k, 850);
    check("ignore_out", out0, 8'h00);
    check("ignore_sdi_high", sdi_hi0 - s, 0);
    repeat (1000) step();
    check("ignore_done_count", done_cnt0 - d, 1);
    check("ignore_busy_after", busy0, 1'b0);
    check("ignore_csx_after", csx0, 1'b1);

    // CPOL=1 / CPHA=1 with SDO stuck high
    check("mode3_sck_idle", sck1, 1'b1);
    v = viol1;
    in1 = 8'h3C; hold1 = 1'b0; load1 = 1'b1;
    step();
    load1 = 1'b0;
    check("mode3_busy_at_accept", busy1, 1'b1);
    check("mode3_sdi_at_accept", sdi1, 1'b0);
    wait_done(1, k);
    check("mode3_latency", k, 850);
    check("mode3_out", out1, 8'hFF);
    check("mode3_sck_end", sck1, 1'b1);
    check("mode3_csx_after", csx1, 1'b1);
    check("mode3_sdi_edge_violations", viol1 - v, 0);
    check("mode3_sdi_bits", cap1, 8'h3C);

    // 16-bit word at HALF=1
    in2 = 16'hBEEF; hold2 = 1'b0; load2 = 1'b1;
    step();
    load2 = 1'b0;
    wait_done(2, k);
    check("w16_latency", k, 33);
    check("w16_out", out2, 16'hBEEF);
    check("w16_csx_after", csx2, 1'b1);
    check("w16_busy_in_done", busy2, 1'b0);
    check("w16_sck_end", sck2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
